// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the shared-memory
// datapath: opcode/flags/memory handshake in, mux selects, strobes and
// CPI counters out.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_en;
  logic             iord;
  logic             memread;
  logic             memwrite;
  logic             irwrite;
  logic             memtoreg;
  logic             regdst;
  logic             regwrite;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       aluop;
  logic [1:0]       pcsource;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] cycles;
  logic [CNT_W-1:0] instructions;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, iord, memread, memwrite, irwrite, memtoreg, regdst,
           regwrite, alusrca, alusrcb, aluop, pcsource, halted, illegal,
           cycles, instructions
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, iord, memread, memwrite, irwrite, memtoreg, regdst,
           regwrite, alusrca, alusrcb, aluop, pcsource, halted, illegal,
           cycles, instructions
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM stepping each instruction through
// fetch/decode/execute/memory/write-back, with memory-ready wait states, a
// sticky HALT and saturating cycle/instruction counters.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (trap illegal opcodes to HALT).
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, RWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT
  } state_t;

  // State-decoded controls; fetch/pcwrite/pcwritecond feed the few
  // outputs that also depend on mem_ready or zero.
  typedef struct packed {
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       halted;
    logic       fetch;
    logic       pcwrite;
    logic       pcwritecond;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  state_t           state, nxt;
  ctrl_t            ctl;
  logic             bad_op;
  logic [CNT_W-1:0] cyc_q, ins_q;

  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.memread = 1'b1; c.alusrcb = 2'b01; c.fetch = 1'b1; end
      DECODE: c.alusrcb = 2'b11;
      MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:  begin c.memread = 1'b1; c.iord = 1'b1; end
      MEMWB:  begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      MEMWR:  begin c.memwrite = 1'b1; c.iord = 1'b1; end
      EXEC:   begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      RWB:    begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      ADDIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      ADDIWB: c.regwrite = 1'b1;
      BRANCH: begin
        c.alusrca = 1'b1; c.aluop = 2'b01;
        c.pcwritecond = 1'b1; c.pcsource = 2'b01;
      end
      JUMP:   begin c.pcwrite = 1'b1; c.pcsource = 2'b10; end
      HALT:   c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection; wait states hold until mem_ready.
  always_comb begin
    nxt    = state;
    bad_op = 1'b0;
    case (state)
      IDLE:   nxt = FETCH;
      FETCH:  if (bus.mem_ready) nxt = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     nxt = EXEC;
          OP_ADDI:      nxt = ADDIEX;
          OP_LW, OP_SW: nxt = MEMADR;
          OP_BEQ:       nxt = BRANCH;
          OP_J:         nxt = JUMP;
          OP_HLT:       nxt = HALT;
          default: begin
            bad_op = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
            nxt = HALT;
`else
            nxt = FETCH;
`endif
          end
        endcase
      end
      MEMADR: nxt = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (bus.mem_ready) nxt = MEMWB;
      MEMWB:  nxt = FETCH;
      MEMWR:  if (bus.mem_ready) nxt = FETCH;
      EXEC:   nxt = RWB;
      RWB:    nxt = FETCH;
      ADDIEX: nxt = ADDIWB;
      ADDIWB: nxt = FETCH;
      BRANCH: nxt = FETCH;
      JUMP:   nxt = FETCH;
      HALT:   nxt = HALT;
      default: nxt = IDLE;
    endcase
  end

  // FSM state plus registered controls decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ctl   <= '0;
    end else begin
      state <= nxt;
      ctl   <= decode_state(nxt);
    end
  end

  // Saturating counters: cycles outside IDLE/HALT, instructions per decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (state != IDLE && state != HALT && cyc_q != '1) cyc_q <= cyc_q + 1'b1;
      if (state == DECODE && ins_q != '1)                 ins_q <= ins_q + 1'b1;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  // Sticky trap flag, set when an unknown opcode sends DECODE to HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          illegal_q <= 1'b0;
    else if (state == DECODE && bad_op)  illegal_q <= 1'b1;
  end
  assign bus.illegal = illegal_q;
`else
  logic unused_bad_op;
  assign unused_bad_op = bad_op;
  assign bus.illegal   = 1'b0;
`endif

  // mem_ready gates IR/PC load only in FETCH; zero only matters in BRANCH.
  assign bus.irwrite  = ctl.fetch & bus.mem_ready;
  assign bus.pc_en    = (ctl.fetch & bus.mem_ready) | ctl.pcwrite |
                        (ctl.pcwritecond & bus.zero);
  assign bus.iord     = ctl.iord;
  assign bus.memread  = ctl.memread;
  assign bus.memwrite = ctl.memwrite;
  assign bus.memtoreg = ctl.memtoreg;
  assign bus.regdst   = ctl.regdst;
  assign bus.regwrite = ctl.regwrite;
  assign bus.alusrca  = ctl.alusrca;
  assign bus.alusrcb  = ctl.alusrcb;
  assign bus.aluop    = ctl.aluop;
  assign bus.pcsource = ctl.pcsource;
  assign bus.halted   = ctl.halted;
  assign bus.cycles       = cyc_q;
  assign bus.instructions = ins_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks lw/sw/beq/add/addi/j/hlt and an
// illegal opcode through the FSM, checking every control output per state.
module tb_multicycle_ctrl;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;

  multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();
  multicycle_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // {pc_en,iord,memread,memwrite,irwrite,memtoreg,regdst,regwrite,
  //  alusrca,alusrcb,aluop,pcsource,halted}
  function automatic logic [15:0] mk(input logic pce, io, mrd, mwr, irw, m2r,
                                     rdst, rw, asa, input logic [1:0] asb,
                                     aop, psrc, input logic hlt);
    return {pce, io, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, hlt};
  endfunction

  function automatic logic [15:0] sig();
    return {bus.pc_en, bus.iord, bus.memread, bus.memwrite, bus.irwrite,
            bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca, bus.alusrcb,
            bus.aluop, bus.pcsource, bus.halted};
  endfunction

  logic [15:0] S_IDLE, S_FRDY, S_FWAIT, S_DEC, S_MADR, S_MRD, S_MWB, S_MWR,
               S_EXEC, S_RWB, S_AWB, S_BRZ, S_BRNZ, S_JUMP, S_HALT;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] exp);
    checks++;
    assert (sig() === exp) passed++;
    else $error("FAIL %s: ctrl got %b want %b", tag, sig(), exp);
  endtask

  task automatic chkv(input string tag, input logic [CNT_W-1:0] got,
                      input logic [CNT_W-1:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0d want %0d", tag, got, exp);
  endtask

  initial begin
    S_IDLE  = '0;
    S_FRDY  = mk(1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
    S_FWAIT = mk(0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
    S_DEC   = mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
    S_MADR  = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    S_MRD   = mk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    S_MWB   = mk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
    S_MWR   = mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    S_EXEC  = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
    S_RWB   = mk(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
    S_AWB   = mk(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);
    S_BRZ   = mk(1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
    S_BRNZ  = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
    S_JUMP  = mk(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0);
    S_HALT  = mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1);

    rst_n = 1'b0; bus.opcode = 6'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    step(); step();
    chk("reset_outputs", S_IDLE);
    chkv("reset_cycles", bus.cycles, 0);
    chkv("reset_instr", bus.instructions, 0);
    chkv("reset_illegal", {31'b0, bus.illegal}, 0);

    // lw, zero wait states
    rst_n = 1'b1; bus.opcode = 6'b100011;
    chk("idle_after_release", S_IDLE);
    step(); chk("lw_fetch", S_FRDY);
    step(); chk("lw_decode", S_DEC);
    step(); chk("lw_memadr", S_MADR);
    step(); chk("lw_memrd", S_MRD);
    step(); chk("lw_memwb", S_MWB);
    step(); chk("lw_next_fetch", S_FRDY);
    chkv("lw_cycles", bus.cycles, 5);
    chkv("lw_instr", bus.instructions, 1);

    // sw with 3 wait cycles in MEMWR
    bus.opcode = 6'b101011;
    step(); chk("sw_decode", S_DEC);
    step(); chk("sw_memadr", S_MADR);
    bus.mem_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = (i == 3);
      chk($sformatf("sw_memwr_%0d", i), S_MWR);
      step();
    end
    chk("sw_next_fetch", S_FRDY);
    chkv("sw_cycles", bus.cycles, 12);
    chkv("sw_instr", bus.instructions, 2);

    // beq taken
    bus.opcode = 6'b000100;
    step(); chk("beq1_decode", S_DEC);
    bus.zero = 1'b1;
    step(); chk("beq1_branch_taken", S_BRZ);
    step(); bus.zero = 1'b0;
    chkv("beq1_cycles", bus.cycles, 15);

    // beq not taken, preceded by one fetch wait cycle
    bus.mem_ready = 1'b0; #1;
    chk("fetch_wait_0", S_FWAIT);
    step(); chk("fetch_wait_1", S_FWAIT);
    bus.mem_ready = 1'b1; #1;
    chk("fetch_ready", S_FRDY);
    step(); chk("beq2_decode", S_DEC);
    step(); chk("beq2_branch_nt", S_BRNZ);
    step();
    chkv("beq2_cycles", bus.cycles, 19);
    chkv("beq2_instr", bus.instructions, 4);

    // lw interrupted by async reset in MEMRD
    bus.opcode = 6'b100011;
    step(); step(); bus.mem_ready = 1'b0;
    step(); chk("rst_mid_memrd_pre", S_MRD);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", S_IDLE);
    chkv("async_reset_cycles", bus.cycles, 0);
    chkv("async_reset_instr", bus.instructions, 0);
    step(); step();
    rst_n = 1'b1; bus.mem_ready = 1'b1;

    // add, addi, j, hlt
    bus.opcode = 6'b000000;
    chk("prog_idle", S_IDLE);
    step(); chk("add_fetch", S_FRDY);
    step(); chk("add_decode", S_DEC);
    step(); chk("add_exec", S_EXEC);
    step(); chk("add_rwb", S_RWB);
    step(); bus.opcode = 6'b001000;
    step(); step(); chk("addi_ex", S_MADR);
    step(); chk("addi_wb", S_AWB);
    step(); bus.opcode = 6'b000010;
    step(); step(); chk("j_jump", S_JUMP);
    step(); bus.opcode = 6'b111111;
    step(); step(); chk("hlt_halt", S_HALT);
    chkv("prog_cycles", bus.cycles, 13);
    chkv("prog_instr", bus.instructions, 4);
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = i[0];
      bus.opcode    = 6'(i);
      step();
    end
    chk("halt_sticky", S_HALT);
    chkv("halt_cycles_frozen", bus.cycles, 13);
    chkv("halt_instr_frozen", bus.instructions, 4);

    // illegal opcode
    rst_n = 1'b0; bus.mem_ready = 1'b1; step();
    rst_n = 1'b1; bus.opcode = 6'b110011;
    step(); step(); step();
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("illegal_halt", S_HALT);
    chkv("illegal_flag", {31'b0, bus.illegal}, 1);
`else
    chk("illegal_nop_fetch", S_FRDY);
    chkv("illegal_flag", {31'b0, bus.illegal}, 0);
`endif
    chkv("illegal_cycles", bus.cycles, 2);
    chkv("illegal_instr", bus.instructions, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle MIPS control unit: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and write-back, driving the datapath muxes and enables cycle by cycle. It succeeds the single-cycle opcode decoder, adding a memory-ready handshake, a sticky halt state, and parametrised cycle/instruction counters that the top-level CPU exposes for CPI reporting. It sits between the instruction register opcode field and the shared-memory multicycle datapath.

## Interface
- `CNT_W`, 32: width of `cycles` and `instructions` counters
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `opcode`  in  6  IR[31:26], stable from DECODE onward
- `zero`  in  1  ALU zero flag (BRANCH state)
- `mem_ready`  in  1  memory completes access this cycle
- `pc_en`  out  1  PC load = pcwrite | (pcwritecond & zero)
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut
- `memread`, `memwrite`  out  1  memory strobes
- `irwrite`  out  1  IR load
- `memtoreg`, `regdst`, `regwrite`  out  1  register-file write controls
- `alusrca`  out  1  0 = PC, 1 = A
- `alusrcb`  out  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm << 2
- `aluop`  out  2  00 add, 01 sub, 10 funct
- `pcsource`  out  2  00 ALU, 01 ALUOut, 10 jump target
- `halted`  out  1  sticky; FSM is in HALT
- `illegal`  out  1  illegal opcode trapped (macro-dependent)
- `cycles`  out  CNT_W  executed cycles
- `instructions`  out  CNT_W  decoded instructions

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT. Outputs are decoded from the state register only, except `pc_en`, which combines `zero`. Unlisted outputs are 0.
- IDLE: all 0. The FSM always moves to FETCH.
- FETCH: `memread`=1, `alusrcb`=01; `irwrite` and the pcwrite term = `mem_ready`. Holds until `mem_ready`, then goes to DECODE.
- DECODE: `alusrcb`=11. Branches on opcode:
  - 000000 → EXEC
  - 001000 → ADDIEX
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 111111 → HALT
  - any other opcode → see Configuration
- MEMADR: `alusrca`=1, `alusrcb`=10. lw → MEMRD, sw → MEMWR.
- MEMRD: `memread`=1, `iord`=1. Holds until `mem_ready`, then MEMWB.
- MEMWB: `regwrite`=1, `memtoreg`=1. Then FETCH.
- MEMWR: `memwrite`=1, `iord`=1. Holds until `mem_ready`, then FETCH.
- EXEC: `alusrca`=1, `aluop`=10. Then RWB, where `regwrite`=1, `regdst`=1. Then FETCH.
- ADDIEX: `alusrca`=1, `alusrcb`=10. Then ADDIWB, where `regwrite`=1. Then FETCH.
- BRANCH: `alusrca`=1, `aluop`=01, pcwritecond=1, `pcsource`=01. Then FETCH.
- JUMP: pcwrite=1, `pcsource`=10. Then FETCH.
- HALT: `halted`=1. Absorbing until reset; `mem_ready` and `opcode` are ignored.
- `cycles`: +1 on every edge where state ≠ IDLE and state ≠ HALT.
- `instructions`: +1 on every edge leaving DECODE, including hlt and illegal opcodes.
- Both counters saturate at all-ones and do not wrap.

## Timing
- Reset (async, any state, mid-access included): state=IDLE, all outputs 0, counters 0, `illegal`=0.
- First FETCH occurs in the 2nd cycle after `rst_n` deasserts.
- Cycles per instruction, with zero wait states:
  - lw 5
  - sw, R-type, addi 4
  - beq, j 3
  - hlt 2, then HALT
- Each low `mem_ready` cycle in FETCH, MEMRD or MEMWR adds exactly one cycle, and `cycles` counts it.
- `mem_ready` outside wait states is ignored.
- `pc_en` is combinational within the BRANCH cycle; `zero` is sampled nowhere else.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined: an illegal opcode in DECODE goes to HALT and sets `illegal`=1 (sticky), with `halted`=1.
- Not defined: an illegal opcode in DECODE returns to FETCH as a NOP (2 cycles), and `illegal` is tied to 0.

## Test plan
- Reset, then lw with `mem_ready`=1 held high → state sequence IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; `regwrite`=`memtoreg`=1 only in MEMWB; `cycles`=5 and `instructions`=1 at the start of the next FETCH.
- sw with `mem_ready` low for 3 cycles in MEMWR → `memwrite`=1 for 4 cycles; instruction takes 7 cycles.
- beq with `zero`=1, then `zero`=0 → `pc_en`=1 with `pcsource`=01 in the first case; `pc_en`=0 in BRANCH in the second.
- Program add, addi, j, hlt → `instructions`=4 and `cycles`=13 (4+4+3+2 = 13); `halted`=1 afterwards, and counters are frozen for 20 further cycles.
- Opcode 6'b110011: with the macro, `illegal`=`halted`=1; without it, the FSM returns to FETCH and `illegal`=0.
- Assert `rst_n` low mid-MEMRD → all outputs 0 immediately, without waiting for a clock edge; after release, fetch restarts from IDLE.
